// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a
// START/DATA/STOP serialiser that sends queued bytes back-to-back, LSB first.
module uart_tx_queue #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              uart_tx
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ZERO = '0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              push;
  logic              pop;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  // A push is refused whenever the registered full flag is set, even if the
  // serialiser pops in the same cycle; the serialiser only pops from IDLE.
  assign push = wr_en & ~full;
  assign pop  = (state == IDLE) & ~empty;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + LVL_ONE;
    else if (!push && pop)
      count_next = count - LVL_ONE;
  end

  // FIFO storage write; stale contents are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and the registered full/empty/overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      full     <= (count_next == LVL_FULL);
      empty    <= (count_next == LVL_ZERO);
      overflow <= wr_en & full;
    end
  end

  // Serialiser FSM; uart_tx and busy are set together with each transition
  // so the line reflects the new state on the cycle right after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            state   <= START;
            uart_tx <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: a queue-and-frame-position model of the
// transmitter checked every cycle, an independent line receiver, and
// directed scenarios with hand-computed literal expectations.
module tb_uart_tx_queue;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * BIT;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            busy;
  logic            uart_tx;

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .busy(busy),
    .uart_tx(uart_tx)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus the position inside the frame on the wire.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_full_now = 1'b0;
  bit         model_valid = 1'b0;
  bit         ovf_seen = 1'b0;

  // Advance the model by one clock using the inputs seen at this edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active    = 1'b0;
      m_pos       = 0;
      m_ovf       = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_full_now = (mq.size() == DEPTH);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME)
          m_active = 1'b0;
      end else if (mq.size() > 0) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (wr_en && !m_full_now)
        mq.push_back(wr_data);
      m_ovf = wr_en && m_full_now;
    end
  end

  function automatic logic model_tx();
    if (!m_active)          return 1'b1;
    if (m_pos < BIT)        return 1'b0;
    if (m_pos < 9 * BIT)    return m_byte[m_pos / BIT - 1];
    return 1'b1;
  endfunction

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("uart_tx", 32'(uart_tx), 32'(model_tx()));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("count", 32'(count), 32'(mq.size()));
      checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
      if (overflow === 1'b1)
        ovf_seen = 1'b1;
    end
  end

  // Independent receiver: decodes frames off the line, sampling mid-bit.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       prev_line = 1'b1;

  // Receiver sampling on the falling edge; reset aborts a partial frame.
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (prev_line === 1'b1 && uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % BIT) == BIT / 2 && rx_cnt / BIT >= 1 && rx_cnt / BIT <= 8)
        rx_sh[rx_cnt / BIT - 1] = uart_tx;
      if (rx_cnt == 9 * BIT + BIT / 2) begin
        rx_active = 1'b0;
        rx_q.push_back(rx_sh);
      end
    end
    prev_line = uart_tx;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sits at posedge+1; the byte is sampled at the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic waitIdle(input int max_cyc, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick(1);
      if (busy === 1'b0 && empty === 1'b1)
        done = 1'b1;
    end
    checkOutput({name, " idle"}, 32'(done), 32'd1);
  endtask

  // Bound the whole run.
  initial begin
    #600_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst full", 32'(full), 32'd0);
    checkOutput("rst empty", 32'(empty), 32'd1);
    checkOutput("rst count", 32'(count), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);

    // Single byte 0x55: start 10 cycles, bits 1,0,...,0, stop, then idle.
    rx_q.delete();
    applyStimulus(8'h55);
    checkOutput("t1 count after push", 32'(count), 32'd1);
    checkOutput("t1 line still idle", 32'(uart_tx), 32'd1);
    tick(1);
    checkOutput("t1 start bit", 32'(uart_tx), 32'd0);
    checkOutput("t1 busy at start", 32'(busy), 32'd1);
    checkOutput("t1 count after pop", 32'(count), 32'd0);
    tick(9);
    checkOutput("t1 start last cycle", 32'(uart_tx), 32'd0);
    tick(1);
    checkOutput("t1 bit0", 32'(uart_tx), 32'd1);
    tick(10);
    checkOutput("t1 bit1", 32'(uart_tx), 32'd0);
    tick(60);
    checkOutput("t1 bit7", 32'(uart_tx), 32'd0);
    tick(10);
    checkOutput("t1 stop bit", 32'(uart_tx), 32'd1);
    checkOutput("t1 busy in stop", 32'(busy), 32'd1);
    tick(9);
    checkOutput("t1 busy last stop", 32'(busy), 32'd1);
    tick(1);
    checkOutput("t1 busy cleared", 32'(busy), 32'd0);
    checkOutput("t1 rx size", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1)
      checkOutput("t1 rx byte", 32'(rx_q[0]), 32'h55);

    // Three consecutive pushes; count peaks at 2.
    rx_q.delete();
    applyStimulus(8'hA3);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("t2 count peak", 32'(count), 32'd2);
    waitIdle(4 * FRAME, "t2");
    checkOutput("t2 rx size", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      checkOutput("t2 rx0", 32'(rx_q[0]), 32'hA3);
      checkOutput("t2 rx1", 32'(rx_q[1]), 32'h00);
      checkOutput("t2 rx2", 32'(rx_q[2]), 32'hFF);
    end

    // Fill the queue behind a byte on the wire; the 17th push overflows.
    rx_q.delete();
    applyStimulus(8'h77);
    tick(1);
    for (int i = 0; i < 16; i++)
      applyStimulus(8'(i));
    checkOutput("t3 full", 32'(full), 32'd1);
    checkOutput("t3 count full", 32'(count), 32'd16);
    applyStimulus(8'h10);
    checkOutput("t3 overflow pulse", 32'(overflow), 32'd1);
    checkOutput("t3 count held", 32'(count), 32'd16);
    tick(1);
    checkOutput("t3 overflow cleared", 32'(overflow), 32'd0);
    waitIdle(18 * (FRAME + 1) + 20, "t3");
    checkOutput("t3 rx size", 32'(rx_q.size()), 32'd17);
    for (int i = 1; i < 17 && i < rx_q.size(); i++)
      checkOutput("t3 rx order", 32'(rx_q[i]), 32'(i - 1));

    // Reset mid-DATA of 0x81 with three bytes queued.
    rx_q.delete();
    applyStimulus(8'h81);
    tick(1);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    tick(40);
    checkOutput("t4 busy before rst", 32'(busy), 32'd1);
    checkOutput("t4 count before rst", 32'(count), 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t4 uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("t4 busy", 32'(busy), 32'd0);
    checkOutput("t4 count", 32'(count), 32'd0);
    checkOutput("t4 empty", 32'(empty), 32'd1);
    tick(3 * FRAME);
    checkOutput("t4 still idle", 32'(busy), 32'd0);
    checkOutput("t4 no frames", 32'(rx_q.size()), 32'd0);

    // Full queue, IDLE pops on the same edge a push arrives.
    rx_q.delete();
    applyStimulus(8'h5A);
    tick(1);
    for (int i = 0; i < 16; i++)
      applyStimulus(8'(8'hC0 + i));
    checkOutput("t5 full", 32'(full), 32'd1);
    tick(84);
    checkOutput("t5 idle gap", 32'(busy), 32'd0);
    checkOutput("t5 full at pop", 32'(full), 32'd1);
    applyStimulus(8'hEE);
    checkOutput("t5 overflow", 32'(overflow), 32'd1);
    checkOutput("t5 count", 32'(count), 32'd15);
    checkOutput("t5 full cleared", 32'(full), 32'd0);
    checkOutput("t5 busy", 32'(busy), 32'd1);
    waitIdle(17 * (FRAME + 1) + 20, "t5");
    checkOutput("t5 rx size", 32'(rx_q.size()), 32'd17);

    // Pointer wrap: four bursts of ten bytes.
    rx_q.delete();
    ovf_seen = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++)
        applyStimulus(8'(8'h30 + b * 10 + i));
      waitIdle(11 * (FRAME + 1), "t6");
    end
    checkOutput("t6 rx size", 32'(rx_q.size()), 32'd40);
    for (int k = 0; k < 40 && k < rx_q.size(); k++)
      checkOutput("t6 rx order", 32'(rx_q[k]), 32'(8'h30 + k));
    checkOutput("t6 no overflow", 32'(ovf_seen), 32'd0);
    checkOutput("t6 empty", 32'(empty), 32'd1);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
